// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: one-cycle hit path, in-order line refill
// with the requested word returned after the whole line has been written.
module inst_cache #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] addr_i,
  input  logic        read_i,
  output logic [31:0] dataQ_o,
  output logic        ready_o,
  input  logic        invalidate_i,
  output logic [31:2] mem_addr_o,
  output logic        mem_read_o,
  input  logic [31:0] mem_dataQ_i,
  input  logic        mem_ready_i,
  output logic        mem_write_o,
  output logic [3:0]  mem_byteSel_o
);

  localparam int unsigned LINES    = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned IDX_LSB  = 2 + OFFSET_BITS;
  localparam int unsigned TAG_LSB  = 2 + OFFSET_BITS + INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESPOND
  } state_t;

  state_t                          r_state;
  state_t                          w_next_state;
  logic [31:2]                     r_req_addr;
  logic                            r_req_valid;
  logic [OFFSET_BITS-1:0]          r_cnt;
  logic [LINES-1:0]                r_valid;
  logic                            r_inv_pend;
  logic [31:0]                     r_resp;
  logic [TAG_BITS-1:0]             r_tag  [LINES];
  logic [31:0]                     r_data [LINES*WORDS];

  logic [TAG_BITS-1:0]             w_req_tag;
  logic [INDEX_BITS-1:0]           w_req_index;
  logic [OFFSET_BITS-1:0]          w_req_word;
  logic [INDEX_BITS+OFFSET_BITS-1:0] w_fill_ptr;
  logic [31:0]                     w_hit_word;
  logic                            w_hit;
  logic                            w_accept;
  logic                            w_ready;
  logic [31:0]                     w_dataQ;
  logic                            w_mem_read;
  logic                            w_fill;
  logic                            w_fill_last;

  assign w_req_tag   = r_req_addr[31:TAG_LSB];
  assign w_req_index = r_req_addr[TAG_LSB-1:IDX_LSB];
  assign w_req_word  = r_req_addr[IDX_LSB-1:2];
  assign w_fill_ptr  = {w_req_index, r_cnt};
  assign w_hit_word  = r_data[{w_req_index, w_req_word}];
  // A lookup coinciding with a flush pulse must not hit on stale contents.
  assign w_hit       = r_req_valid && r_valid[w_req_index] &&
                       (r_tag[w_req_index] == w_req_tag) && !invalidate_i;

  assign ready_o       = w_ready;
  assign dataQ_o       = w_dataQ;
  assign mem_read_o    = w_mem_read;
  assign mem_addr_o    = {w_req_tag, w_req_index, r_cnt};
  assign mem_write_o   = 1'b0;
  assign mem_byteSel_o = 4'b1111;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state, request acceptance and output decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_ready      = 1'b0;
    w_dataQ      = '0;
    w_mem_read   = 1'b0;
    w_fill       = 1'b0;
    w_fill_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_req_valid) begin
          if (w_hit) begin
            w_ready  = 1'b1;
            w_dataQ  = w_hit_word;
            w_accept = read_i;
          end else begin
            w_next_state = S_REFILL;
          end
        end else begin
          w_accept = read_i;
        end
      end
      S_REFILL: begin
        w_mem_read = 1'b1;
        if (mem_ready_i) begin
          w_fill = 1'b1;
          if (r_cnt == '1) begin
            w_fill_last  = 1'b1;
            w_next_state = S_RESPOND;
          end
        end
      end
      S_RESPOND: begin
        w_ready      = 1'b1;
        w_dataQ      = r_resp;
        w_accept     = read_i;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request register, refill counter, response capture and valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_addr  <= '0;
      r_req_valid <= 1'b0;
      r_cnt       <= '0;
      r_valid     <= '0;
      r_inv_pend  <= 1'b0;
      r_resp      <= '0;
    end else begin
      if (w_accept) begin
        r_req_addr  <= addr_i;
        r_req_valid <= 1'b1;
      end else if (w_ready || w_fill_last) begin
        r_req_valid <= 1'b0;
      end
      if (w_fill) begin
        r_cnt <= w_fill_last ? '0 : r_cnt + OFFSET_BITS'(1);
        if (r_cnt == w_req_word) r_resp <= mem_dataQ_i;
      end
      // A flush seen at any point of a refill keeps the refilled line invalid.
      if (invalidate_i)                     r_valid <= '0;
      else if (w_fill_last && !r_inv_pend)  r_valid[w_req_index] <= 1'b1;
      if (w_fill_last)                              r_inv_pend <= 1'b0;
      else if (r_state == S_REFILL && invalidate_i) r_inv_pend <= 1'b1;
    end
  end

  // Tag and data arrays, written only by refill, never reset.
  always_ff @(posedge clk) begin
    if (!rst && w_fill)      r_data[w_fill_ptr]  <= mem_dataQ_i;
    if (!rst && w_fill_last) r_tag[w_req_index]  <= w_req_tag;
  end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with a 3-cycle memory model.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] addr_i = '0;
  logic        read_i = 1'b0;
  logic        invalidate_i = 1'b0;
  logic [31:0] mem_dataQ_i = '0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] dataQ_o;
  logic        ready_o;
  logic [29:0] mem_addr_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [3:0]  mem_byteSel_o;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned mem_reads = 0;
  int unsigned lat_cnt = 0;
  int unsigned addr_jump = 0;
  int unsigned bad_dq = 0;
  int unsigned ready_events = 0;
  int unsigned log_n = 0;
  int unsigned last_ready_cyc = 0;
  int unsigned resp_cyc = 0;
  logic [29:0] prev_addr = '0;
  logic [29:0] mem_log [16];
  logic        force_ready = 1'b0;

  inst_cache #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .read_i(read_i),
    .dataQ_o(dataQ_o), .ready_o(ready_o), .invalidate_i(invalidate_i),
    .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o),
    .mem_dataQ_i(mem_dataQ_i), .mem_ready_i(mem_ready_i),
    .mem_write_o(mem_write_o), .mem_byteSel_o(mem_byteSel_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: line 0x40..0x43 holds 0xA0..0xA3, elsewhere 0xD0000000|addr.
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (a[29:2] == 28'h10) return 32'hA0 + {30'b0, a[1:0]};
    return 32'hD000_0000 | {2'b00, a};
  endfunction

  // Memory responder: mem_ready_i on the third cycle a read has been visible.
  always @(negedge clk) begin
    mem_ready_i = 1'b0;
    if (force_ready) begin
      mem_ready_i = 1'b1;
      mem_dataQ_i = 32'hBAD0_0000;
      lat_cnt = 0;
    end else if (mem_read_o) begin
      if (lat_cnt != 0 && mem_addr_o !== prev_addr) addr_jump++;
      prev_addr = mem_addr_o;
      lat_cnt++;
      if (lat_cnt == 3) begin
        mem_ready_i = 1'b1;
        mem_dataQ_i = mem_word(mem_addr_o);
        lat_cnt = 0;
        mem_reads++;
        if (log_n < 16) mem_log[log_n] = mem_addr_o;
        log_n++;
        last_ready_cyc = cyc + 1;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  // Output monitor.
  always @(negedge clk) begin
    if (ready_o) ready_events++;
    if (!ready_o && dataQ_o !== 32'h0) bad_dq++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one read and wait (bounded) for its response; lat counts cycles after acceptance.
  task automatic read_wait(input logic [29:0] a, output logic [31:0] d,
                           output int unsigned lat, output logic ok);
    addr_i = a;
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    ok = 1'b0;
    d = '0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1'b1;
        d = dataQ_o;
        lat = i;
        resp_cyc = cyc;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    read_i = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready_o); end
    n_checks++; if (dataQ_o !== 32'h0) begin n_fail++; $display("FAIL reset_dataQ: got %h expected 00000000", dataQ_o); end
    n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b expected 0", mem_read_o); end
    n_checks++; if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL mem_write_const: got %b expected 0", mem_write_o); end
    n_checks++; if (mem_byteSel_o !== 4'hF) begin n_fail++; $display("FAIL byteSel_const: got %h expected f", mem_byteSel_o); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    logic [31:0] d;
    int unsigned lat;
    logic ok;
    int unsigned r0;
    r0 = mem_reads;
    log_n = 0;
    read_wait(30'h40, d, lat, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cold_timeout: ready_o=0 after 60 cycles, expected a response"); end
    n_checks++; if (d !== 32'hA0) begin n_fail++; $display("FAIL cold_data: got %h expected 000000a0", d); end
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL cold_latency: got %0d expected 14", lat); end
    n_checks++; if (mem_reads - r0 != 4) begin n_fail++; $display("FAIL cold_mem_reads: got %0d expected 4", mem_reads - r0); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem_log[i] !== 30'h40 + 30'(i)) begin n_fail++; $display("FAIL cold_addr_%0d: got %h expected %h", i, mem_log[i], 30'h40 + 30'(i)); end
    end
    n_checks++; if (resp_cyc != last_ready_cyc) begin n_fail++; $display("FAIL cold_resp_timing: got cycle %0d expected %0d", resp_cyc, last_ready_cyc); end
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL cold_one_cycle: ready_o got %b expected 0", ready_o); end
    step();
  endtask

  task automatic test_hit_stream();
    int unsigned r0;
    logic [31:0] exp;
    r0 = mem_reads;
    addr_i = 30'h41;
    read_i = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) addr_i = 30'h42 + 30'(i);
      else read_i = 1'b0;
      @(negedge clk);
      exp = 32'hA1 + 32'(i);
      n_checks++; if ({ready_o, dataQ_o} !== {1'b1, exp}) begin n_fail++; $display("FAIL hit_%0d: ready=%b data=%h expected ready=1 data=%h", i, ready_o, dataQ_o, exp); end
      n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL hit_mem_read_%0d: got %b expected 0", i, mem_read_o); end
      step();
    end
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL hit_stream_end: ready_o got %b expected 0", ready_o); end
    step();
    n_checks++; if (mem_reads != r0) begin n_fail++; $display("FAIL hit_no_mem: got %0d reads expected 0", mem_reads - r0); end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    int unsigned lat;
    logic ok;
    log_n = 0;
    read_wait(30'h440, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hD000_0440) begin n_fail++; $display("FAIL conflict_data: ok=%b got %h expected d0000440", ok, d); end
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL conflict_latency: got %0d expected 14", lat); end
    n_checks++; if (mem_log[0] !== 30'h440 || mem_log[3] !== 30'h443) begin n_fail++; $display("FAIL conflict_addr: got %h..%h expected 440..443", mem_log[0], mem_log[3]); end
    read_wait(30'h40, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hA0) begin n_fail++; $display("FAIL evict_data: ok=%b got %h expected 000000a0", ok, d); end
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL evict_latency: got %0d expected 14", lat); end
    read_wait(30'h42, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hA2 || lat != 1) begin n_fail++; $display("FAIL refetch_hit: ok=%b data=%h lat=%0d expected data=000000a2 lat=1", ok, d, lat); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int unsigned lat;
    logic ok;
    invalidate_i = 1'b1;
    step();
    invalidate_i = 1'b0;
    read_wait(30'h41, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hA1) begin n_fail++; $display("FAIL flush_data: ok=%b got %h expected 000000a1", ok, d); end
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL flush_latency: got %0d expected 14", lat); end
    // Flush while refilling line 0x80.
    addr_i = 30'h81;
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    repeat (5) step();
    invalidate_i = 1'b1;
    step();
    invalidate_i = 1'b0;
    ok = 1'b0;
    d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; d = dataQ_o; break; end
    end
    n_checks++; if (!ok || d !== 32'hD000_0081) begin n_fail++; $display("FAIL flush_refill_resp: ok=%b got %h expected d0000081", ok, d); end
    step();
    read_wait(30'h81, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hD000_0081 || lat != 14) begin n_fail++; $display("FAIL flush_refill_reread: ok=%b data=%h lat=%0d expected data=d0000081 lat=14", ok, d, lat); end
    read_wait(30'h41, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hA1 || lat != 14) begin n_fail++; $display("FAIL flush_refill_other: ok=%b data=%h lat=%0d expected data=000000a1 lat=14", ok, d, lat); end
  endtask

  task automatic test_inv_lookup();
    logic [31:0] d;
    logic ok;
    int unsigned r0;
    r0 = mem_reads;
    addr_i = 30'h42;
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    invalidate_i = 1'b1;
    @(negedge clk);
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL inv_lookup_miss: ready_o got %b expected 0", ready_o); end
    step();
    invalidate_i = 1'b0;
    ok = 1'b0;
    d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; d = dataQ_o; break; end
    end
    step();
    n_checks++; if (!ok || d !== 32'hA2) begin n_fail++; $display("FAIL inv_lookup_data: ok=%b got %h expected 000000a2", ok, d); end
    n_checks++; if (mem_reads - r0 != 4) begin n_fail++; $display("FAIL inv_lookup_reads: got %0d expected 4", mem_reads - r0); end
  endtask

  task automatic test_inv_last_word();
    logic [31:0] d;
    int unsigned lat;
    logic ok;
    int unsigned found;
    addr_i = 30'hC0;
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    repeat (12) step();
    invalidate_i = 1'b1;
    step();
    invalidate_i = 1'b0;
    found = 0;
    d = '0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ready_o) begin found = i; d = dataQ_o; break; end
    end
    step();
    n_checks++; if (found != 1 || d !== 32'hD000_00C0) begin n_fail++; $display("FAIL inv_last_resp: at %0d data=%h expected at 1 data=d00000c0", found, d); end
    read_wait(30'hC0, d, lat, ok);
    n_checks++; if (!ok || lat != 14) begin n_fail++; $display("FAIL inv_last_reread: ok=%b lat=%0d expected lat=14", ok, lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int unsigned lat;
    logic ok;
    int unsigned r0;
    int unsigned ev0;
    r0 = mem_reads;
    ev0 = ready_events;
    addr_i = 30'h100;
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    repeat (7) step();
    n_checks++; if (mem_reads - r0 != 2) begin n_fail++; $display("FAIL rstmid_words: got %0d expected 2", mem_reads - r0); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    force_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_read_o !== 1'b0 || ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: mem_read=%b ready=%b expected 0 0", mem_read_o, ready_o); end
    step();
    force_ready = 1'b0;
    repeat (10) step();
    @(negedge clk);
    n_checks++; if (ready_events != ev0) begin n_fail++; $display("FAIL rstmid_no_resp: got %0d ready cycles expected 0", ready_events - ev0); end
    n_checks++; if (mem_read_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray_ready: mem_read got %b expected 0", mem_read_o); end
    step();
    read_wait(30'h100, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hD000_0100 || lat != 14) begin n_fail++; $display("FAIL rstmid_reread: ok=%b data=%h lat=%0d expected data=d0000100 lat=14", ok, d, lat); end
  endtask

  task automatic test_critical_word();
    logic [31:0] d;
    int unsigned lat;
    logic ok;
    log_n = 0;
    read_wait(30'h4B, d, lat, ok);
    n_checks++; if (!ok || d !== 32'hD000_004B) begin n_fail++; $display("FAIL crit_data: ok=%b got %h expected d000004b", ok, d); end
    n_checks++; if (lat != 14 || resp_cyc != last_ready_cyc) begin n_fail++; $display("FAIL crit_timing: lat=%0d cycle=%0d expected lat=14 cycle=%0d", lat, resp_cyc, last_ready_cyc); end
    n_checks++; if (mem_log[0] !== 30'h48 || mem_log[3] !== 30'h4B) begin n_fail++; $display("FAIL crit_order: got %h..%h expected 48..4b", mem_log[0], mem_log[3]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic ok;
    addr_i = 30'h200;
    read_i = 1'b1;
    step();
    read_i = 1'b0;
    ok = 1'b0;
    d = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ready_o) begin ok = 1'b1; d = dataQ_o; break; end
    end
    n_checks++; if (!ok || d !== 32'hD000_0200) begin n_fail++; $display("FAIL b2b_miss: ok=%b got %h expected d0000200", ok, d); end
    read_i = 1'b1;
    addr_i = 30'h201;
    step();
    read_i = 1'b0;
    @(negedge clk);
    n_checks++; if ({ready_o, dataQ_o} !== {1'b1, 32'hD000_0201}) begin n_fail++; $display("FAIL b2b_after_respond: ready=%b data=%h expected ready=1 data=d0000201", ready_o, dataQ_o); end
    step();
  endtask

  task automatic test_monitors();
    n_checks++; if (bad_dq != 0) begin n_fail++; $display("FAIL dataQ_idle_zero: got %0d nonzero cycles expected 0", bad_dq); end
    n_checks++; if (addr_jump != 0) begin n_fail++; $display("FAIL mem_addr_stable: got %0d changes expected 0", addr_jump); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stream();
    test_conflict();
    test_flush();
    test_inv_lookup();
    test_inv_last_word();
    test_reset_mid();
    test_critical_word();
    test_back_to_back();
    test_monitors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
